complete_encoder: RTL and testbench
===================================

Name: complete_encoder

Overview:
- Transmit-side counterpart of the team's Huffman decode chain.
- Accepts 32-bit words, each holding eight 4-bit symbols.
- Huffman-encodes each symbol with the team's fixed code table, packs the variable-length codes MSB-first into 32-bit output words, and emits each word with a valid strobe.
- The output bitstream is exactly what the serializer plus huffman_decoder consume.

Parameters:
- None. Word width 32 and symbol width 4 are fixed by the code table.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- load  input  1  word-accept request; honoured only while in_ready=1.
- in  input  32  eight symbols; in[31:28] is encoded first, in[3:0] last.
- flush  input  1  emit the partial packed word; honoured only in IDLE.
- in_ready  output  1  high in IDLE.
- out_data  output  32  packed codes, first bit at bit 31, unused low bits 0.
- out_bits  output  6  valid bit count in out_data: 32 for full words, 1..31 for a flush.
- out_valid  output  1  one-cycle strobe qualifying out_data/out_bits.

Behaviour:
- Code table (symbol: code, sent left to right):
  - 0:00, 1:010, 2:011, 3:100, 4:101
  - 5:11000, 6:11001, 7:11010, 8:11011, 9:11100
  - 10:111010, 11:111011, 12:111100, 13:111101, 14:111110, 15:111111
  - Maximum code length is 6.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Accumulator and fill count cnt are cleared.
  - out_data=0, out_bits=0, out_valid=0, in_ready=1.
  - Partial bits are discarded.
- FSM states: IDLE, ENC.
- IDLE:
  - load=1 captures in into a shift register, clears symbol counter k, and moves to ENC.
  - in_ready is 0 from the next cycle.
- ENC, one symbol per cycle for k=0..7:
  - Look up code/length L for the current top nibble and append it at accumulator position cnt.
  - cnt_next = cnt+L.
  - After k=7 the FSM returns to IDLE. in_ready stays low for exactly 8 cycles after the accept edge.
- Word emission:
  - When cnt+L >= 32, the first 32 bits go to out_data with out_bits=32 and out_valid=1 in the following cycle.
  - The remaining cnt+L-32 bits (0..5) move to accumulator bits 31 and down; cnt = cnt+L-32.
  - cnt+L == 32 emits the word and leaves cnt=0.
  - At most one emission per cycle, guaranteed since L<=6.
- Flush (IDLE, flush=1, load=0):
  - If cnt>0: out_data=accumulator with bits below cnt zero, out_bits=cnt, out_valid=1 next cycle; cnt cleared.
  - If cnt==0: no output.
- Simultaneous load and flush in IDLE: load wins and flush is dropped.
- load or flush while in ENC: ignored, no side effects.
- out_valid:
  - High for exactly one cycle per emission.
  - out_data and out_bits hold their last values after the strobe.
- No output backpressure: the consumer must accept every out_valid strobe.
- Latency: a word boundary crossed during ENC cycle k appears on outputs one cycle later.

Test Plan:
- Reset, then load in=32'h00000000 → 8 cycles of ENC, no out_valid (16 bits). Then flush → out_data=32'h00000000, out_bits=16, out_valid for 1 cycle. in_ready=1 afterwards.
- load in=32'h01234567 (29 bits), then flush → out_data=32'h139719D0, out_bits=29.
- load in=32'hFFFFFFFF (48 bits):
  - During symbol 5 (6th symbol), out_data=32'hFFFFFFFF and out_bits=32, strobed the following cycle.
  - Then flush → out_data=32'hFFFF0000, out_bits=16.
- Back-to-back loads 32'h00000000 twice (32 bits) → exactly one out_valid with 32'h00000000/32 on the cycle after the second word's last symbol; a following flush produces nothing.
- load asserted during ENC and flush with cnt==0 → ignored: no extra out_valid, in_ready timing unchanged. load+flush together in IDLE → only load takes effect.
- Pull rst low mid-ENC after 32'hFFFFFFFF:
  - Outputs go to 0 immediately, in_ready=1.
  - After release, a flush produces no output (partial data discarded).

Source files
------------

// File: rtl/complete_encoder.sv
// Huffman encoder: eight 4-bit symbols per accepted word, variable-length codes
// packed MSB-first into 32-bit output words, with a flush for the partial word.
module complete_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] in,
    input  logic        flush,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_bits,
    output logic        out_valid
);

    typedef enum logic {IDLE, ENC} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_shift;
    logic [2:0]  r_k;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_out_data;
    logic [5:0]  r_out_bits;
    logic        r_out_valid;

    logic [5:0]  w_code;
    logic [2:0]  w_len;
    logic [63:0] w_ins;
    logic [63:0] w_merge;
    logic [6:0]  w_sum;
    logic        w_emit;
    logic [5:0]  w_cnt_next;
    logic        w_accept;
    logic        w_flush;

    // Codes are held left-aligned in 6 bits so they can be placed with one shift.
    always_comb begin
        w_code = '0;
        w_len  = 3'd2;
        case (r_shift[31:28])
            4'd0:  begin w_code = 6'b000000; w_len = 3'd2; end
            4'd1:  begin w_code = 6'b010000; w_len = 3'd3; end
            4'd2:  begin w_code = 6'b011000; w_len = 3'd3; end
            4'd3:  begin w_code = 6'b100000; w_len = 3'd3; end
            4'd4:  begin w_code = 6'b101000; w_len = 3'd3; end
            4'd5:  begin w_code = 6'b110000; w_len = 3'd5; end
            4'd6:  begin w_code = 6'b110010; w_len = 3'd5; end
            4'd7:  begin w_code = 6'b110100; w_len = 3'd5; end
            4'd8:  begin w_code = 6'b110110; w_len = 3'd5; end
            4'd9:  begin w_code = 6'b111000; w_len = 3'd5; end
            4'd10: begin w_code = 6'b111010; w_len = 3'd6; end
            4'd11: begin w_code = 6'b111011; w_len = 3'd6; end
            4'd12: begin w_code = 6'b111100; w_len = 3'd6; end
            4'd13: begin w_code = 6'b111101; w_len = 3'd6; end
            4'd14: begin w_code = 6'b111110; w_len = 3'd6; end
            default: begin w_code = 6'b111111; w_len = 3'd6; end
        endcase
    end

    // 64-bit window: upper half is the word being filled, lower half the spill-over.
    assign w_ins      = {w_code, 58'b0} >> r_cnt;
    assign w_merge    = {r_acc, 32'b0} | w_ins;
    assign w_sum      = {1'b0, r_cnt} + {4'b0, w_len};
    assign w_emit     = (w_sum >= 7'd32);
    assign w_cnt_next = w_emit ? {1'b0, w_sum[4:0]} : w_sum[5:0];

    assign w_accept = (r_state == IDLE) && load;
    assign w_flush  = (r_state == IDLE) && flush && !load && (r_cnt != 6'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (load) w_state_next = ENC;
            ENC:     if (r_k == 3'd7) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_bits  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_shift <= in;
                r_k     <= '0;
            end else if (r_state == ENC) begin
                r_shift <= {r_shift[27:0], 4'b0};
                r_k     <= r_k + 3'd1;
                r_cnt   <= w_cnt_next;
                if (w_emit) begin
                    r_out_data  <= w_merge[63:32];
                    r_out_bits  <= 6'd32;
                    r_out_valid <= 1'b1;
                    r_acc       <= w_merge[31:0];
                end else begin
                    r_acc <= w_merge[63:32];
                end
            end else if (w_flush) begin
                r_out_data  <= r_acc;
                r_out_bits  <= r_cnt;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_data  = r_out_data;
    assign out_bits  = r_out_bits;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_complete_encoder.sv
// Bench for complete_encoder: hand-computed vector table, directed corner cases,
// and random traffic checked against a bit-queue model of the code stream.
module tb_complete_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] in;
    logic        flush;
    logic        in_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_valid;

    complete_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in        (in),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  b;
        int unsigned c;
    } emit_t;

    emit_t mon_q[$];
    emit_t exp_q[$];

    always @(negedge clk)
        if (rst && out_valid) mon_q.push_back('{d: out_data, b: out_bits, c: cyc});

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the code stream as a queue of bits.
    string codes[16] = '{"00", "010", "011", "100", "101", "11000", "11001", "11010",
                         "11011", "11100", "111010", "111011", "111100", "111101",
                         "111110", "111111"};
    bit mq[$];

    task automatic m_load(input logic [31:0] w, input int unsigned a);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] s;
            string c;
            s = w[31-4*k -: 4];
            c = codes[s];
            for (int j = 0; j < c.len(); j++) mq.push_back(c.getc(j) == 8'h31);
            if (mq.size() >= 32) begin
                logic [31:0] word;
                word = '0;
                for (int i = 0; i < 32; i++) word[31-i] = mq.pop_front();
                exp_q.push_back('{d: word, b: 6'd32, c: a + 1 + k});
            end
        end
    endtask

    task automatic m_flush(input int unsigned f);
        if (mq.size() > 0) begin
            logic [31:0] word;
            int n;
            n = mq.size();
            word = '0;
            for (int i = 0; i < n; i++) word[31-i] = mq.pop_front();
            exp_q.push_back('{d: word, b: n[5:0], c: f});
        end
    endtask

    task automatic do_load(input logic [31:0] w, input bit wf, input bit poke,
                           output int unsigned a);
        int lowcnt;
        in = w; load = 1'b1; flush = wf;
        @(posedge clk); #1;
        load = 1'b0; flush = 1'b0;
        a = cyc;
        m_load(w, a);
        lowcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (poke && i == 3) begin
                load = 1'b1; flush = 1'b1; in = ~w;
            end
            if (!in_ready) lowcnt++;
            @(posedge clk); #1;
            load = 1'b0; flush = 1'b0;
        end
        chk("in_ready_low_cycles", lowcnt, 8);
        chk("in_ready_back", in_ready, 1'b1);
    endtask

    task automatic do_flush(output int unsigned f);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        f = cyc;
        m_flush(f);
    endtask

    task automatic drain_check(input string nm);
        int n;
        @(negedge clk); #1;
        chk({nm, "_count"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_data"}, mon_q[i].d, exp_q[i].d);
            chk({nm, "_bits"}, mon_q[i].b, exp_q[i].b);
            chk({nm, "_cycle"}, mon_q[i].c, exp_q[i].c);
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [31:0] w;
        bit          has_full;
        int unsigned full_k;
        logic [31:0] full_d;
        logic [31:0] tail_d;
        logic [5:0]  tail_b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int unsigned a, a2, f;

        vecs[0] = '{w: 32'h00000000, has_full: 0, full_k: 0, full_d: 32'h0,
                    tail_d: 32'h00000000, tail_b: 6'd16};
        vecs[1] = '{w: 32'h01234567, has_full: 0, full_k: 0, full_d: 32'h0,
                    tail_d: 32'h139719D0, tail_b: 6'd29};
        vecs[2] = '{w: 32'hFFFFFFFF, has_full: 1, full_k: 5, full_d: 32'hFFFFFFFF,
                    tail_d: 32'hFFFF0000, tail_b: 6'd16};
        vecs[3] = '{w: 32'h89ABCDEF, has_full: 1, full_k: 5, full_d: 32'hDF3AEFCF,
                    tail_d: 32'h7EFC0000, tail_b: 6'd14};

        rst = 1'b0; load = 1'b0; flush = 1'b0; in = '0;
        #12;
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_bits", out_bits, 6'd0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Hand-computed vectors, each from an empty accumulator.
        foreach (vecs[v]) begin
            do_load(vecs[v].w, 1'b0, 1'b0, a);
            @(negedge clk); #1;
            chk("vec_full_count", mon_q.size(), vecs[v].has_full ? 1 : 0);
            if (vecs[v].has_full && mon_q.size() > 0) begin
                chk("vec_full_data", mon_q[0].d, vecs[v].full_d);
                chk("vec_full_bits", mon_q[0].b, 6'd32);
                chk("vec_full_cycle", mon_q[0].c, a + 1 + vecs[v].full_k);
            end
            mon_q.delete();
            do_flush(f);
            @(negedge clk); #1;
            chk("vec_tail_count", mon_q.size(), 1);
            if (mon_q.size() > 0) begin
                chk("vec_tail_data", mon_q[0].d, vecs[v].tail_d);
                chk("vec_tail_bits", mon_q[0].b, vecs[v].tail_b);
                chk("vec_tail_cycle", mon_q[0].c, f);
            end
            mon_q.delete();
            exp_q.delete();
            mq.delete();
            repeat (2) @(posedge clk);
            #1;
            chk("hold_data", out_data, vecs[v].tail_d);
            chk("hold_bits", out_bits, vecs[v].tail_b);
            chk("hold_valid_low", out_valid, 1'b0);
        end

        // Back-to-back zero words: exactly one full word, after the second word's last symbol.
        do_load(32'h00000000, 1'b0, 1'b0, a);
        do_load(32'h00000000, 1'b0, 1'b0, a2);
        chk("b2b_model_count", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("b2b_model_cycle", exp_q[0].c, a2 + 8);
        drain_check("b2b");
        do_flush(f);
        drain_check("b2b_flush_empty");

        // load/flush during ENC are ignored; flush with nothing buffered is silent.
        do_load(32'h01234567, 1'b0, 1'b1, a);
        drain_check("enc_poke");
        do_flush(f);
        drain_check("enc_poke_flush");
        do_flush(f);
        drain_check("flush_empty");

        // load and flush together: only load acts.
        do_load(32'h00000000, 1'b0, 1'b0, a);
        do_load(32'h01234567, 1'b1, 1'b0, a2);
        drain_check("load_flush_same");
        do_flush(f);
        drain_check("load_flush_tail");

        // Asynchronous reset mid-ENC, while the emission strobe is high.
        in = 32'hFFFFFFFF; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_reset_data", out_data, 32'h0);
        chk("async_reset_bits", out_bits, 6'd0);
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        mq.delete();
        mon_q.delete();
        exp_q.delete();
        do_flush(f);
        drain_check("post_reset_flush");

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            int unsigned r;
            logic [31:0] w;
            r = $urandom_range(0, 9);
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w = w | 32'h88888888;
            if (r < 6) begin
                do_load(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), a);
            end else if (r < 9) begin
                do_flush(f);
            end else begin
                @(posedge clk); #1;
            end
            drain_check("rand");
        end
        do_flush(f);
        drain_check("rand_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
